// File: rtl/memory_cycle.sv
// Memory pipeline stage: forwards ALU results, runs data-memory loads/stores
// with busywait handshaking, and stalls upstream while an access is pending.
//
// state  | meaning
// IDLE   | accepting execute-stage instructions; ALU results pass in one cycle
// ACCESS | memory request outstanding; strobes held until busywait drops
module memory_cycle (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidE,
  input  logic        RegWriteE,
  input  logic        JtypeE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [5:0]  ALUSelectE,
  input  logic [1:0]  StoreTypeE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] StoreDataE,
  input  logic [4:0]  WriteAddressE,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  output logic        StallM,
  output logic        ValidM,
  output logic        RegWriteM,
  output logic        JtypeM,
  output logic        MemReadM,
  output logic [5:0]  ALUSelectM,
  output logic [31:0] ALUOutM,
  output logic [31:0] DataMemOutM,
  output logic [4:0]  WriteAddressM,
  output logic        MisalignM,
  output logic [15:0] WaitCycles
);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;

  logic        holdRegWrite, holdJtype, holdMemRead;
  logic [5:0]  holdALUSelect;
  logic [31:0] holdALUOut;
  logic [4:0]  holdWriteAddress;

  logic        isMemOp, misaligned;
  logic [3:0]  laneEnable;
  logic [31:0] laneData;

  assign StallM     = (state == ACCESS);
  assign isMemOp    = MemReadE | MemWriteE;
  assign misaligned = ((StoreTypeE == 2'b01) & ALUOutE[0]) |
                      (StoreTypeE[1] & (ALUOutE[1:0] != 2'b00));

  // Loads always fetch the full word; stores replicate data across lanes.
  always_comb begin
    laneEnable = 4'b1111;
    laneData   = StoreDataE;
    case (StoreTypeE)
      2'b00: begin
        laneEnable = 4'b0001 << ALUOutE[1:0];
        laneData   = {4{StoreDataE[7:0]}};
      end
      2'b01: begin
        laneEnable = 4'b0011 << ALUOutE[1:0];
        laneData   = {2{StoreDataE[15:0]}};
      end
      default: ;
    endcase
    if (MemReadE) laneEnable = 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_address      <= '0;
      mem_writedata    <= '0;
      mem_byteenable   <= '0;
      ValidM           <= 1'b0;
      RegWriteM        <= 1'b0;
      JtypeM           <= 1'b0;
      MemReadM         <= 1'b0;
      ALUSelectM       <= '0;
      ALUOutM          <= '0;
      DataMemOutM      <= '0;
      WriteAddressM    <= '0;
      MisalignM        <= 1'b0;
      WaitCycles       <= '0;
      holdRegWrite     <= 1'b0;
      holdJtype        <= 1'b0;
      holdMemRead      <= 1'b0;
      holdALUSelect    <= '0;
      holdALUOut       <= '0;
      holdWriteAddress <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!ValidE) begin
            ValidM    <= 1'b0;
            RegWriteM <= 1'b0;
            MisalignM <= 1'b0;
          end else if (isMemOp && !misaligned) begin
            state            <= ACCESS;
            holdRegWrite     <= RegWriteE;
            holdJtype        <= JtypeE;
            holdMemRead      <= MemReadE;
            holdALUSelect    <= ALUSelectE;
            holdALUOut       <= ALUOutE;
            holdWriteAddress <= WriteAddressE;
            mem_read         <= MemReadE;
            mem_write        <= MemWriteE & ~MemReadE;
            mem_address      <= {ALUOutE[31:2], 2'b00};
            mem_writedata    <= laneData;
            mem_byteenable   <= laneEnable;
            ValidM           <= 1'b0;
            RegWriteM        <= 1'b0;
            MisalignM        <= 1'b0;
          end else begin
            // Plain ALU op, or a misaligned access reported without a request.
            ValidM        <= 1'b1;
            RegWriteM     <= RegWriteE & ~isMemOp;
            JtypeM        <= JtypeE;
            MemReadM      <= MemReadE;
            ALUSelectM    <= ALUSelectE;
            ALUOutM       <= ALUOutE;
            WriteAddressM <= WriteAddressE;
            DataMemOutM   <= '0;
            MisalignM     <= isMemOp;
          end
        end
        ACCESS: begin
          if (WaitCycles != 16'hFFFF) WaitCycles <= WaitCycles + 16'd1;
          if (!mem_busywait) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            ValidM        <= 1'b1;
            RegWriteM     <= holdRegWrite;
            JtypeM        <= holdJtype;
            MemReadM      <= holdMemRead;
            ALUSelectM    <= holdALUSelect;
            ALUOutM       <= holdALUOut;
            WriteAddressM <= holdWriteAddress;
            DataMemOutM   <= holdMemRead ? mem_readdata : 32'd0;
            MisalignM     <= 1'b0;
          end else begin
            ValidM    <= 1'b0;
            RegWriteM <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 `clk`  in  1  rising-edge clock for all state.
REQ-003 `reset`  in  1  synchronous, active-high reset.
REQ-004 `ValidE`  in  1  execute stage presents a valid instruction.
REQ-005 `RegWriteE, JtypeE, MemReadE, MemWriteE`  in  1 each  control signals from the execute stage.
REQ-006 `ALUSelectE`  in  6  load/ALU select, passed through unchanged.
REQ-007 `StoreTypeE`  in  2  store width: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 `ALUOutE`  in  32  ALU result; also the memory address.
REQ-009 `StoreDataE`  in  32  rs2 data for stores.
REQ-010 `WriteAddressE`  in  5  destination register.
REQ-011 `mem_read, mem_write`  out  1 each  registered data-memory request strobes.
REQ-012 `mem_address`  out  32  registered, word-aligned address ({addr[31:2], 2'b00}).
REQ-013 `mem_writedata`  out  32  registered store data, lane-shifted.
REQ-014 `mem_byteenable`  out  4  registered byte-lane enables.
REQ-015 `mem_readdata`  in  32  raw word from data memory.
REQ-016 `mem_busywait`  in  1  memory not yet complete.
REQ-017 `StallM`  out  1  freeze the upstream stages.
REQ-018 `ValidM, RegWriteM, JtypeM, MemReadM`  out  1 each  registered outputs to the write-back stage.
REQ-019 `ALUSelectM`  out  6; `ALUOutM`  out  32; `DataMemOutM`  out  32; `WriteAddressM`  out  5  registered outputs to the write-back stage.
REQ-020 `MisalignM`  out  1  registered misaligned-access flag.
REQ-021 `WaitCycles`  out  16  saturating count of stall cycles.

Function
REQ-022 The FSM SHALL have two states: IDLE and ACCESS; StallM SHALL be 1 exactly when state == ACCESS, decoded combinationally from the state register.
REQ-023 In IDLE with ValidE=1 and neither MemReadE nor MemWriteE set, the next edge SHALL:
- load all *M outputs from the *E inputs;
- set ValidM=1 and DataMemOutM=0;
- give a latency of one cycle.
REQ-024 In IDLE with ValidE=0, the next edge SHALL set ValidM=0, RegWriteM=0 and MisalignM=0; the other *M outputs SHALL hold their values.
REQ-025 Misalignment SHALL be defined as: half access with addr[0]=1, or word access with addr[1:0]!=0, where the access width for MemReadE is taken from StoreTypeE.
REQ-026 In IDLE with ValidE=1, a memory operation, and a misaligned address, the next edge SHALL:
- load the *M outputs;
- set ValidM=1, MisalignM=1 and RegWriteM=0;
- issue no memory strobe;
- stay in IDLE.
REQ-027 In IDLE with ValidE=1, a memory operation, and an aligned address, the next edge SHALL:
- go to ACCESS;
- latch the *E controls, address and data into internal hold registers;
- assert mem_read=MemReadE and mem_write=MemWriteE;
- set ValidM=0.
REQ-028 If MemReadE and MemWriteE are both set, the access SHALL be treated as a read only (mem_write=0).
REQ-029 Store lanes SHALL be:
- byte: enable 4'b0001<<addr[1:0], data {4{d[7:0]}};
- half: enable 4'b0011<<addr[1:0], data {2{d[15:0]}};
- word: enable 4'b1111, data d.
REQ-030 For loads, mem_byteenable SHALL be 4'b1111.
REQ-031 In ACCESS, the strobes, address, data and enables SHALL remain stable every cycle until completion.
REQ-032 In ACCESS, any cycle with mem_busywait=0 at the rising edge SHALL be completion, and that edge SHALL:
- capture mem_readdata into DataMemOutM (0 for stores);
- load the *M outputs from the hold registers, with ValidM=1;
- deassert mem_read and mem_write;
- return to IDLE.
REQ-033 The minimum memory-access latency SHALL be 2 cycles (issue edge plus completion edge).
REQ-034 In ACCESS with mem_busywait=1, ValidM SHALL be 0 and RegWriteM SHALL be 0, so bubbles reach write-back.
REQ-035 The *E inputs SHALL be ignored while in ACCESS; the upstream stage holds them because StallM=1.
REQ-036 WaitCycles SHALL increment on every cycle with StallM=1 and saturate at 16'hFFFF.
REQ-037 No new request SHALL be accepted on the completion edge; back-to-back memory operations SHALL be separated by at least one IDLE cycle.

Reset
REQ-038 On a reset edge, the block SHALL enter IDLE.
REQ-039 On a reset edge, all outputs SHALL be set to 0: *M outputs, strobes, mem_address, mem_writedata, mem_byteenable, MisalignM and WaitCycles.
REQ-040 Reset SHALL take priority over every other event.
REQ-041 A reset during ACCESS SHALL drop the request at that edge, with no completion produced.

Verification
REQ-042 ALU pass-through: ValidE=1, ALUOutE=0x1234, RegWriteE=1, WriteAddressE=5 → next cycle ValidM=1, ALUOutM=0x1234, WriteAddressM=5, RegWriteM=1, StallM=0.
REQ-043 Load with busywait for 3 cycles: MemReadE=1, address 0x100, mem_readdata=0xDEADBEEF → mem_read=1 with mem_address=0x100 for 4 cycles, StallM=1 for 4 cycles, then DataMemOutM=0xDEADBEEF with ValidM=1, and WaitCycles=4.
REQ-044 Byte store to address 0x103 with data 0xAB → mem_byteenable=4'b1000, mem_writedata=0xABABABAB, mem_write=1; after completion ValidM=1 and DataMemOutM=0.
REQ-045 Misaligned word load at 0x102 → mem_read never asserted, MisalignM=1, ValidM=1, RegWriteM=0, StallM=0.
REQ-046 Reset asserted while in ACCESS with mem_busywait=1 → next cycle state IDLE, mem_read=0, ValidM=0, WaitCycles=0.
REQ-047 MemReadE=1 and MemWriteE=1 together → only mem_read asserts; mem_write stays 0 throughout.
